// File: rtl/mem_ss_csr_regfile.sv
// mem_ss_csr_regfile
//   CSR register file for the memory subsystem, parametrised for NUM_CH
//   channels, presented to the host CSR fabric as a 32-bit Avalon-MM slave.
//   CSR group (at CSR_OFFSET): VERSION, FEAT_LIST, FEAT_LIST_2, IF_ATTR,
//   SCRATCH, STATUS and CH_ATTR[0..7].
//   EFFMON group (at EFFMON_OFFSET): CTRL, CYCLES, WR_BEATS[c], RD_BEATS[c].
//
//   Optional feature macro: MEM_SS_CSR_EFFMON_EN
//     defined   -> efficiency monitor counters and CTRL are built
//     undefined -> EFFMON group reads 0, writes ignored, beat strobes unused
//
// Ports:
//   clk, rst_n                 single clock, synchronous active-low reset
//   avmm_*                     Avalon-MM slave (byte address, bits [1:0] ignored)
//   cal_success / cal_fail     per-channel calibration status, asynchronous
//   ch_wr_beat / ch_rd_beat    per-channel one-cycle beat strobes
//
// Handshake: a read or write is accepted on a clk edge where it is asserted
// and avmm_waitrequest is 0. An accepted read returns avmm_readdata with
// avmm_readdatavalid high in the following cycle; one read per cycle, fully
// pipelined. A simultaneous read and write applies the write and returns the
// pre-write value.
module mem_ss_csr_regfile #(
  parameter int                NUM_CH           = 1,
  parameter int                ADDR_W           = 16,
  parameter logic [ADDR_W-1:0] CSR_OFFSET       = 16'h6000,
  parameter logic [ADDR_W-1:0] EFFMON_OFFSET    = 16'h1000,
  parameter logic [15:0]       MAJ_VER          = 16'h1,
  parameter logic [7:0]        MIN_VER          = 8'h0,
  parameter logic [7:0]        MEM_TYPE         = 8'h1,
  parameter logic [1:0]        IF_TYPE          = 2'h0,
  parameter logic              AUTO_PRECHARGE   = 1'b1,
  parameter logic [2:0]        NUM_USR_POOLS    = 3'h1,
  parameter logic [3:0]        NUM_WR_CPY       = 4'h1,
  parameter logic [3:0]        RDY_LATENCY      = 4'h3,
  parameter logic              EFFMON_START_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] avmm_address,
  input  logic              avmm_read,
  input  logic              avmm_write,
  input  logic [31:0]       avmm_writedata,
  input  logic [3:0]        avmm_byteenable,
  output logic              avmm_waitrequest,
  output logic [31:0]       avmm_readdata,
  output logic              avmm_readdatavalid,
  input  logic [NUM_CH-1:0] cal_success,
  input  logic [NUM_CH-1:0] cal_fail,
  input  logic [NUM_CH-1:0] ch_wr_beat,
  input  logic [NUM_CH-1:0] ch_rd_beat
);

  localparam int WA = ADDR_W - 2;

  localparam logic [31:0] VERSION_VAL   = {MAJ_VER, MIN_VER, 8'h0};
  localparam logic [31:0] FEAT_LIST_VAL = {8'h0, MEM_TYPE, 14'h0, IF_TYPE};
  localparam logic [31:0] FEAT_2_VAL    = {28'h0, 4'(NUM_CH)};
  localparam logic [31:0] CH_ATTR_VAL   = {4'h0, AUTO_PRECHARGE, NUM_USR_POOLS,
                                           NUM_WR_CPY, 16'h0, RDY_LATENCY};

  // Word index of a group-relative byte offset.
  function automatic logic [WA-1:0] wa(input logic [11:0] byte_off);
    return WA'(byte_off >> 2);
  endfunction

  logic              rd_acc;
  logic              wr_acc;
  logic [ADDR_W-1:0] csr_off;
  logic [WA-1:0]     csr_word;
  logic [2:0]        ch_idx;
  logic [31:0]       scratch;
  logic [31:0]       rd_mux;
  logic [31:0]       status_val;
  logic [NUM_CH-1:0] succ_m, succ_s, fail_m, fail_s;
  logic              unused_ok;

  assign rd_acc   = avmm_read  & ~avmm_waitrequest;
  assign wr_acc   = avmm_write & ~avmm_waitrequest;
  // Wrapping subtraction: only addresses inside the group land on small offsets.
  assign csr_off  = avmm_address - CSR_OFFSET;
  assign csr_word = csr_off[ADDR_W-1:2];
  assign ch_idx   = csr_off[4:2];

  assign status_val = 32'(succ_s) | (32'(fail_s) << 16);

  // waitrequest is held for the first cycle out of reset, then never again.
  always_ff @(posedge clk) begin
    if (!rst_n) avmm_waitrequest <= 1'b1;
    else        avmm_waitrequest <= 1'b0;
  end

  // Two-flop synchronisers for the asynchronous calibration status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      succ_m <= '0;
      succ_s <= '0;
      fail_m <= '0;
      fail_s <= '0;
    end else begin
      succ_m <= cal_success;
      succ_s <= succ_m;
      fail_m <= cal_fail;
      fail_s <= fail_m;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scratch <= '0;
    end else if (wr_acc && csr_word == wa(12'h020)) begin
      for (int b = 0; b < 4; b++) begin
        if (avmm_byteenable[b]) scratch[8*b +: 8] <= avmm_writedata[8*b +: 8];
      end
    end
  end

`ifdef MEM_SS_CSR_EFFMON_EN
  logic [ADDR_W-1:0] eff_off;
  logic [ADDR_W-1:0] beat_off;
  logic [WA-1:0]     eff_word;
  logic              beat_hit;
  logic [2:0]        beat_ch;
  logic              beat_rd;
  logic              ctrl_wr;
  logic              start;
  logic [31:0]       cycles;
  logic [31:0]       wr_beats [NUM_CH];
  logic [31:0]       rd_beats [NUM_CH];

  assign eff_off  = avmm_address - EFFMON_OFFSET;
  assign eff_word = eff_off[ADDR_W-1:2];
  // Beat registers start at 0x10, two words per channel: WR then RD.
  assign beat_off = eff_off - ADDR_W'('h10);
  assign beat_hit = (beat_off[ADDR_W-1:6] == '0);
  assign beat_ch  = beat_off[5:3];
  assign beat_rd  = beat_off[2];
  assign ctrl_wr  = wr_acc && eff_word == wa(12'h000) && avmm_byteenable[0];

  // CLEAR is applied at the accepting edge so counters read 0 from the next
  // cycle on; it overrides any increment sampled at that same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start  <= EFFMON_START_RST;
      cycles <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        wr_beats[c] <= '0;
        rd_beats[c] <= '0;
      end
    end else begin
      if (ctrl_wr) start <= avmm_writedata[0];
      if (ctrl_wr && avmm_writedata[1]) begin
        cycles <= '0;
        for (int c = 0; c < NUM_CH; c++) begin
          wr_beats[c] <= '0;
          rd_beats[c] <= '0;
        end
      end else if (start) begin
        if (cycles != '1) cycles <= cycles + 32'd1;
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_wr_beat[c] && wr_beats[c] != '1) wr_beats[c] <= wr_beats[c] + 32'd1;
          if (ch_rd_beat[c] && rd_beats[c] != '1) rd_beats[c] <= rd_beats[c] + 32'd1;
        end
      end
    end
  end

  assign unused_ok = ^{eff_off[1:0], beat_off[1:0]};
`else
  assign unused_ok = ^{ch_wr_beat, ch_rd_beat, EFFMON_OFFSET, EFFMON_START_RST};
`endif

  always_comb begin
    rd_mux = '0;
    if      (csr_word == wa(12'h000)) rd_mux = VERSION_VAL;
    else if (csr_word == wa(12'h004)) rd_mux = FEAT_LIST_VAL;
    else if (csr_word == wa(12'h008)) rd_mux = FEAT_2_VAL;
    else if (csr_word == wa(12'h020)) rd_mux = scratch;
    else if (csr_word == wa(12'h050)) rd_mux = status_val;
    else if (csr_word >= wa(12'h100) && csr_word <= wa(12'h11C)) begin
      if ({29'd0, ch_idx} < 32'(NUM_CH)) rd_mux = CH_ATTR_VAL;
    end
`ifdef MEM_SS_CSR_EFFMON_EN
    if      (eff_word == wa(12'h000)) rd_mux = {31'd0, start};
    else if (eff_word == wa(12'h004)) rd_mux = cycles;
    else if (beat_hit) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (beat_ch == 3'(c)) rd_mux = beat_rd ? rd_beats[c] : wr_beats[c];
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      avmm_readdatavalid <= 1'b0;
      avmm_readdata      <= '0;
    end else begin
      avmm_readdatavalid <= rd_acc;
      if (rd_acc) avmm_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_mem_ss_csr_regfile.sv
module tb_mem_ss_csr_regfile;

  localparam int NUM_CH = 4;
  localparam logic [15:0] CSR = 16'h6000;
  localparam logic [15:0] EFF = 16'h1000;

  logic              clk;
  logic              rst_n;
  logic [15:0]       avmm_address;
  logic              avmm_read;
  logic              avmm_write;
  logic [31:0]       avmm_writedata;
  logic [3:0]        avmm_byteenable;
  logic              avmm_waitrequest;
  logic [31:0]       avmm_readdata;
  logic              avmm_readdatavalid;
  logic [NUM_CH-1:0] cal_success;
  logic [NUM_CH-1:0] cal_fail;
  logic [NUM_CH-1:0] ch_wr_beat;
  logic [NUM_CH-1:0] ch_rd_beat;

  int total = 0;
  int bad   = 0;

  mem_ss_csr_regfile #(.NUM_CH(NUM_CH)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .avmm_address       (avmm_address),
    .avmm_read          (avmm_read),
    .avmm_write         (avmm_write),
    .avmm_writedata     (avmm_writedata),
    .avmm_byteenable    (avmm_byteenable),
    .avmm_waitrequest   (avmm_waitrequest),
    .avmm_readdata      (avmm_readdata),
    .avmm_readdatavalid (avmm_readdatavalid),
    .cal_success        (cal_success),
    .cal_fail           (cal_fail),
    .ch_wr_beat         (ch_wr_beat),
    .ch_rd_beat         (ch_rd_beat)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Checker
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Drivers
  task automatic wait_ready(input string tag);
    int n = 0;
    while (avmm_waitrequest === 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n == 10) chk({tag, "_waitreq_timeout"}, 32'(avmm_waitrequest), 32'd0);
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [31:0] data,
                           input logic [3:0] be);
    @(negedge clk);
    wait_ready("wr");
    avmm_address    = addr;
    avmm_writedata  = data;
    avmm_byteenable = be;
    avmm_write      = 1'b1;
    @(posedge clk);
    #1;
    avmm_write = 1'b0;
  endtask

  // Read with data check; also checks readdatavalid timing (high exactly the
  // cycle after acceptance, low again the cycle after that).
  task automatic bus_read(input string tag, input logic [15:0] addr,
                          input logic [31:0] exp);
    @(negedge clk);
    wait_ready(tag);
    avmm_address = addr;
    avmm_read    = 1'b1;
    @(posedge clk);
    #1;
    avmm_read = 1'b0;
    chk({tag, "_rdv"}, 32'(avmm_readdatavalid), 32'd1);
    chk(tag, avmm_readdata, exp);
    @(posedge clk);
    #1;
    chk({tag, "_rdv_drop"}, 32'(avmm_readdatavalid), 32'd0);
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] wm, input logic [NUM_CH-1:0] rm,
                       input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ch_wr_beat = wm;
      ch_rd_beat = rm;
      @(posedge clk);
      #1;
      ch_wr_beat = '0;
      ch_rd_beat = '0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    avmm_address = '0;
    avmm_read = 1'b0;
    avmm_write = 1'b0;
    avmm_writedata = '0;
    avmm_byteenable = '0;
    cal_success = '0;
    cal_fail = '0;
    ch_wr_beat = '0;
    ch_rd_beat = '0;

    // Reset and release
    repeat (3) @(posedge clk);
    #1;
    chk("rst_waitreq", 32'(avmm_waitrequest), 32'd1);
    chk("rst_rdv", 32'(avmm_readdatavalid), 32'd0);
    chk("rst_rdata", avmm_readdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("waitreq_first_cycle", 32'(avmm_waitrequest), 32'd1);
    @(posedge clk);
    #1;
    chk("waitreq_released", 32'(avmm_waitrequest), 32'd0);

    // Constant registers
    bus_read("version", CSR + 16'h000, 32'h0001_0000);
    bus_read("feat_list", CSR + 16'h004, 32'h0001_0000);
    bus_read("feat_list_2", CSR + 16'h008, 32'h0000_0004);
    bus_read("if_attr", CSR + 16'h010, 32'h0);
    for (int c = 0; c < 4; c++)
      bus_read($sformatf("ch_attr%0d", c), CSR + 16'h100 + 16'(4 * c), 32'h0910_0003);
    bus_read("ch_attr4", CSR + 16'h110, 32'h0);
    bus_read("ch_attr7", CSR + 16'h11C, 32'h0);
    bus_read("unmapped", CSR + 16'h024, 32'h0);
    bus_read("scratch_rst", CSR + 16'h020, 32'h0);
    bus_read("status_rst", CSR + 16'h050, 32'h0);

    // Scratch and byte enables
    bus_write(CSR + 16'h020, 32'hDEAD_BEEF, 4'hF);
    bus_read("scratch_full", CSR + 16'h020, 32'hDEAD_BEEF);
    bus_write(CSR + 16'h020, 32'h1234_5678, 4'b0101);
    bus_read("scratch_be", CSR + 16'h020, 32'hDE34_BE78);
    bus_write(CSR + 16'h000, 32'hFFFF_FFFF, 4'hF);
    bus_read("version_ro", CSR + 16'h000, 32'h0001_0000);

    // Simultaneous read and write: pre-write value returned
    @(negedge clk);
    avmm_address = CSR + 16'h020;
    avmm_writedata = 32'hCAFE_F00D;
    avmm_byteenable = 4'hF;
    avmm_write = 1'b1;
    avmm_read = 1'b1;
    @(posedge clk);
    #1;
    avmm_write = 1'b0;
    avmm_read = 1'b0;
    chk("rw_same_rdv", 32'(avmm_readdatavalid), 32'd1);
    chk("rw_same_old", avmm_readdata, 32'hDE34_BE78);
    bus_read("rw_same_new", CSR + 16'h020, 32'hCAFE_F00D);

    // Status synchronisation
    @(negedge clk);
    cal_success = 4'b0101;
    cal_fail = 4'b1000;
    repeat (3) @(posedge clk);
    bus_read("status", CSR + 16'h050, 32'h0008_0005);

`ifdef MEM_SS_CSR_EFFMON_EN
    bus_read("ctrl_rst", EFF + 16'h000, 32'h1);
    // Clear and keep START=1
    bus_write(EFF + 16'h000, 32'h3, 4'h1);
    pulse(4'b0010, 4'b0010, 7);
    pulse(4'b0010, 4'b0000, 3);
    bus_read("wr_beats1", EFF + 16'h018, 32'd10);
    bus_read("rd_beats1", EFF + 16'h01C, 32'd7);
    bus_read("wr_beats0", EFF + 16'h010, 32'd0);
    bus_read("rd_beats2", EFF + 16'h024, 32'd0);
    bus_read("wr_beats4_unmapped", EFF + 16'h030, 32'd0);
    // Freeze
    bus_write(EFF + 16'h000, 32'h0, 4'h1);
    bus_read("ctrl_stopped", EFF + 16'h000, 32'h0);
    pulse(4'b0010, 4'b0010, 5);
    bus_read("wr_beats1_frozen", EFF + 16'h018, 32'd10);
    bus_read("rd_beats1_frozen", EFF + 16'h01C, 32'd7);
    // Saturation
    bus_write(EFF + 16'h000, 32'h1, 4'h1);
    @(negedge clk);
    dut.wr_beats[0] = 32'hFFFF_FFFE;
    pulse(4'b0001, 4'b0000, 3);
    bus_read("wr_beats0_sat", EFF + 16'h010, 32'hFFFF_FFFF);
    // CLEAR together with a beat; START dropped by the same write
    @(negedge clk);
    avmm_address = EFF + 16'h000;
    avmm_writedata = 32'h2;
    avmm_byteenable = 4'h1;
    avmm_write = 1'b1;
    ch_wr_beat = 4'b0011;
    @(posedge clk);
    #1;
    avmm_write = 1'b0;
    ch_wr_beat = '0;
    bus_read("clr_wr_beats0", EFF + 16'h010, 32'd0);
    bus_read("clr_wr_beats1", EFF + 16'h018, 32'd0);
    bus_read("clr_rd_beats1", EFF + 16'h01C, 32'd0);
    bus_read("clr_cycles", EFF + 16'h004, 32'd0);
    bus_read("clr_ctrl", EFF + 16'h000, 32'd0);
`else
    bus_write(EFF + 16'h000, 32'h1, 4'hF);
    pulse(4'b1111, 4'b1111, 4);
    bus_read("noeff_ctrl", EFF + 16'h000, 32'd0);
    bus_read("noeff_cycles", EFF + 16'h004, 32'd0);
    for (int c = 0; c < NUM_CH; c++) begin
      bus_read($sformatf("noeff_wr%0d", c), EFF + 16'h010 + 16'(8 * c), 32'd0);
      bus_read($sformatf("noeff_rd%0d", c), EFF + 16'h014 + 16'(8 * c), 32'd0);
    end
`endif

    // Reset mid-transaction drops a pending readdatavalid
    @(negedge clk);
    avmm_address = CSR + 16'h000;
    avmm_read = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    avmm_read = 1'b0;
    chk("rst_mid_rdv", 32'(avmm_readdatavalid), 32'd0);
    chk("rst_mid_waitreq", 32'(avmm_waitrequest), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    bus_read("scratch_after_rst", CSR + 16'h020, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_ss_csr_regfile.md
Name: mem_ss_csr_regfile

Overview:
Parametrised CSR register file for the memory subsystem, the successor to the fixed single-channel CSR definitions. Implements version, feature, interface attribute, scratch, status and per-channel attribute registers for NUM_CH channels, plus an efficiency monitor with per-channel read/write beat counters. Sits behind the host CSR fabric as a 32-bit Avalon-MM slave. Status inputs come from the EMIF calibration logic; beat strobes come from the per-channel AXI4 user ports.

Parameters:
NUM_CH, 1, number of memory channels; legal range 1..8
ADDR_W, 16, byte-address width
CSR_OFFSET, 16'h6000, base of the CSR register group
EFFMON_OFFSET, 16'h1000, base of the efficiency monitor group
MAJ_VER, 16'h1, major version
MIN_VER, 8'h0, minor version
MEM_TYPE, 8'h1, memory type; 1 = DDR4
IF_TYPE, 2'h0, interface type; 0 = AXI4
AUTO_PRECHARGE, 1'b1, channel attribute
NUM_USR_POOLS, 3'h1, channel attribute
NUM_WR_CPY, 4'h1, channel attribute
RDY_LATENCY, 4'h3, channel attribute
EFFMON_START_RST, 1'b1, reset value of EFFMON CTRL.START

Ports:
clk  in  1  single clock for the whole block
rst_n  in  1  synchronous, active-low reset
avmm_address  in  ADDR_W  byte address; bits [1:0] ignored
avmm_read  in  1  read request
avmm_write  in  1  write request
avmm_writedata  in  32  write data
avmm_byteenable  in  4  write byte enables
avmm_waitrequest  out  1  slave not ready
avmm_readdata  out  32  read data
avmm_readdatavalid  out  1  read data valid
cal_success  in  NUM_CH  per-channel calibration pass; asynchronous
cal_fail  in  NUM_CH  per-channel calibration fail; asynchronous
ch_wr_beat  in  NUM_CH  one-cycle pulse per accepted AXI W beat
ch_rd_beat  in  NUM_CH  one-cycle pulse per accepted AXI R beat

Behaviour:
- Reset (rst_n low at a clk edge) values:
  - waitrequest = 1; readdatavalid = 0; readdata = 0.
  - SCRATCH = 0; sync flops = 0; all counters = 0; CTRL.START = EFFMON_START_RST.
- waitrequest stays 1 for the first cycle after rst_n rises, then remains 0.
- A request is accepted when waitrequest = 0.
- Reads:
  - readdatavalid pulses exactly 1 cycle after an accepted read.
  - One read per cycle, fully pipelined.
- Read and write in the same cycle: the write is applied; the read returns the pre-write value.
- Writes:
  - Honour byteenable on RW fields only.
  - Writes to RO or unmapped addresses are ignored.
  - Reads of unmapped addresses return 0.
- CSR map (byte offsets from CSR_OFFSET):
  - 0x00 VERSION RO = {MAJ_VER, MIN_VER, 8'h0}
  - 0x04 FEAT_LIST RO = {8'h0, MEM_TYPE, 14'h0, IF_TYPE}
  - 0x08 FEAT_LIST_2 RO = {28'h0, NUM_CH[3:0]}
  - 0x10 IF_ATTR RO = 0
  - 0x20 SCRATCH RW 32-bit
  - 0x50 STATUS RO: bit[c] = synced cal_success[c]; bit[16+c] = synced cal_fail[c]; all other bits 0.
  - 0x100+4*c CH_ATTR RO = {4'h0, AUTO_PRECHARGE, NUM_USR_POOLS, NUM_WR_CPY, 16'h0, RDY_LATENCY} for c < NUM_CH; 0 for c >= NUM_CH (up to c = 7).
- Status synchronisation: two-flop synchroniser per bit, so STATUS reflects an input change 2–3 cycles later.
- EFFMON map (byte offsets from EFFMON_OFFSET):
  - 0x00 CTRL:
    - bit0 START RW.
    - bit1 CLEAR: write-1 pulse, self-clearing, always reads 0.
    - Other bits read 0.
  - 0x04 CYCLES: 32-bit, increments every cycle while START = 1.
  - 0x10+8*c WR_BEATS[c]; 0x14+8*c RD_BEATS[c]; c < NUM_CH; others read 0.
- Counter rules:
  - Count only while START = 1.
  - Saturate at 32'hFFFF_FFFF; never wrap.
  - CLEAR takes effect on the cycle after the write is accepted. All counters go to 0 that cycle; CLEAR wins over a simultaneous beat or cycle increment.
  - A START = 0 write freezes all counters. Values stay readable.
- Reset mid-transaction: a pending readdatavalid is dropped; no partial write is applied.

Optional Feature:
MEM_SS_CSR_EFFMON_EN
- Defined: the efficiency monitor is implemented as described.
- Undefined: no counters or CTRL are instantiated. The whole EFFMON group reads 0 and writes are ignored. ch_wr_beat and ch_rd_beat are unused. The CSR group is unchanged.

Test Plan:
- Reset release, NUM_CH=4 -> waitrequest=1 for one cycle after rst_n rises. Then:
  - VERSION reads 32'h0001_0000.
  - FEAT_LIST reads 32'h0001_0000.
  - FEAT_LIST_2 reads 32'h4.
  - CH_ATTR[0..3] read 32'h0910_0003.
  - CH_ATTR[4] reads 0.
  - readdatavalid lands exactly 1 cycle after each read.
- Write SCRATCH 32'hDEAD_BEEF with byteenable 4'hF, then write 32'h1234_5678 with byteenable 4'b0101 -> SCRATCH reads 32'hDE34_BE78. A write to VERSION leaves it unchanged.
- Drive cal_success=4'b0101, cal_fail=4'b1000 -> STATUS reads 32'h0008_0005 within 3 cycles.
- START=1; pulse ch_wr_beat[1] 10 times and ch_rd_beat[1] 7 times -> WR_BEATS[1]=10, RD_BEATS[1]=7, other channels 0. Write START=0, pulse 5 more times -> counts unchanged.
- Force WR_BEATS[0] near saturation (hierarchical preload 32'hFFFF_FFFE) and pulse 3 beats -> reads 32'hFFFF_FFFF. Write CLEAR in the same cycle as a beat -> all counters read 0; CTRL bit1 reads 0.
- Build without MEM_SS_CSR_EFFMON_EN -> CTRL, CYCLES and all beat registers read 0; the scratch and status tests still pass.
